tx_scramble_sequencer: RTL and testbench
========================================

# tx_scramble_sequencer

Transmit PCS stage directly upstream of the TX gearbox. It accepts 66-bit blocks from the 64b/66b encoder as two 32-bit beats, each with a header. It scrambles the payload with the self-synchronous x^58 + x^39 + 1 polynomial and generates the gearbox sequence count and pause. It presents data, header, sequence and pause to the gearbox as one registered, cycle-aligned bundle.

## Interface

- DATA_WIDTH, 32: payload beat width. Fixed; other values are unsupported.
- HEADER_WIDTH, 2: sync header width.
- SEQUENCE_WIDTH, 6: gearbox sequence counter width.
- SEQ_MAX, 32: terminal sequence value, which is the pause slot.

Ports (clock and reset first):

- i_clk  input  1  single clock. All logic is in this domain.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_data  input  32  encoded payload beat, bit 0 transmitted first.
- i_header  input  2  sync header. Meaningful on beat 0 of a block; passed through on every beat.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  beat accepted when i_valid && o_ready.
- o_data  output  32  scrambled payload to the gearbox.
- o_header  output  2  registered header, never scrambled.
- o_gearbox_seq  output  6  sequence value aligned with o_data.
- o_pause  output  1  high when o_gearbox_seq == SEQ_MAX. The gearbox must not load data on that cycle.
- o_underflow  output  1  sticky flag: a slot was missed because upstream was not valid.

## Operation

**Enable flag en_q**
- Reset value 0.
- Set on the first clock edge after reset release.
- o_ready = en_q && (cnt_q != SEQ_MAX). This is combinational from registers only.

**Sequence counter cnt_q**
- Reset value 0.
- While en_q is set, advances every cycle: 0, 1, …, 32, 0.
- Wraps 32 -> 0.
- 33 cycles carry 16 blocks (32 beats) plus one pause cycle.

**Output register update** (every edge while en_q is set)
- o_gearbox_seq <= cnt_q.
- o_pause <= (cnt_q == SEQ_MAX).

**Accepted beat** (i_valid && o_ready)
- o_data <= scramble(i_data).
- o_header <= i_header.
- The scrambler state advances by 32 bits.

**Pause slot** (cnt_q == SEQ_MAX)
- No beat is accepted, and i_valid is ignored.
- o_data and o_header hold their previous values.
- The scrambler state holds.

**Underflow** (en_q set, cnt_q != SEQ_MAX, i_valid low)
- A zero payload word is scrambled and the state advances.
- o_header <= 2'b00.
- o_underflow is set and stays set until reset.
- The counter is never stalled; the line rate is fixed.

**Scrambler**
- State S holds the last 58 scrambled bits.
- Reset value: all ones.
- Bit-serial equivalent, LSB first: out[n] = in[n] ^ out[n-39] ^ out[n-58]. The new out[n] shifts into S.
- All 32 bits of a beat are computed combinationally in one cycle.

**Reset behaviour**
- Reset mid-operation asynchronously clears every register: o_data=0, o_header=0, o_gearbox_seq=0, o_pause=0, o_underflow=0, o_ready=0, cnt_q=0, S=all ones.

## Timing

- Latency from i_data to o_data is 1 cycle.
- o_data, o_header, o_gearbox_seq and o_pause always change on the same edge.
- o_ready is low in the cycle where cnt_q == 32. o_pause is high in the following cycle.
- The upstream encoder may rely on o_ready being known at the start of each cycle. There is no combinational path from i_valid to o_ready.
- After reset release: cycle 1 sets en_q; from cycle 2, o_ready=1 and beats are accepted.

## Configuration

**TX_SCRAMBLER_EN**
- Defined: the scrambler is active as described above.
- Undefined:
  - o_data <= i_data unmodified.
  - The scrambler state register is not instantiated.
  - Underflow still forces the payload to zero and sets o_underflow.
- Sequencing and handshake are identical in both builds.

## Structure

**Shared package pcs_pkg**
- DATA_WIDTH, HEADER_WIDTH, SEQUENCE_WIDTH, SEQ_MAX.
- SCR_TAP_A=39, SCR_TAP_B=58, SCR_RESET=58'h3FF_FFFF_FFFF_FFFF.
- Sync header constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10.

**Sub-module tx_scrambler**
- Holds the 58-bit state and the 32-bit parallel next-state/output logic.
- Has an advance enable and the same asynchronous reset.
- Reused by the future PRBS/loopback path.

## Test plan

- Reset release, then i_valid=1 with i_data=0 continuously: first accepted beat gives o_data=32'h0000_0000, second gives o_data=32'h03FF_FF80 (TX_SCRAMBLER_EN defined).
- Run 66 cycles with continuous valid:
  - o_gearbox_seq steps 0..32, 0..32.
  - o_pause is high only at 32.
  - o_ready is low exactly one cycle before each o_pause.
  - 64 beats are accepted.
- Drive i_valid=1 with distinct i_data at cnt_q=32: the beat is not consumed; o_data/o_header hold; the same beat is accepted next cycle.
- Drop i_valid for one cycle at cnt_q=5:
  - o_data = scramble(0).
  - o_header = 2'b00.
  - o_underflow rises and stays 1 through subsequent valid traffic.
- Assert i_reset_n=0 mid-stream at cnt_q=17: all outputs are 0 immediately. After release, o_ready=0 for 1 cycle, then the sequence restarts at 0 and the scrambler restarts from all ones.
- Build without TX_SCRAMBLER_EN and drive i_data=32'hDEAD_BEEF, i_header=2'b10: one cycle later, o_data=32'hDEAD_BEEF and o_header=2'b10.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared PCS transmit constants and types: beat/header/sequence widths,
// gearbox pause slot, scrambler taps and reset seed, and sync headers.
package pcs_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int HEADER_WIDTH   = 2;
    localparam int SEQUENCE_WIDTH = 6;

    localparam logic [SEQUENCE_WIDTH-1:0] SEQ_MAX = 6'd32;

    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;
    localparam logic [SCR_TAP_B-1:0] SCR_RESET = 58'h3FF_FFFF_FFFF_FFFF;

    localparam logic [HEADER_WIDTH-1:0] SYNC_DATA = 2'b01;
    localparam logic [HEADER_WIDTH-1:0] SYNC_CTRL = 2'b10;

    typedef logic [DATA_WIDTH-1:0]     beat_t;
    typedef logic [HEADER_WIDTH-1:0]   header_t;
    typedef logic [SEQUENCE_WIDTH-1:0] seq_t;
    typedef logic [SCR_TAP_B-1:0]      scr_state_t;

endpackage

// File: rtl/tx_scrambler.sv
// Self-synchronous x^58 + x^39 + 1 scrambler, 32 bits per advance.
// state_q[0] is the most recently produced scrambled bit, state_q[k] the
// bit produced k+1 bits ago. o_data is combinational from state_q and
// i_data; the state only moves when i_advance is high.
module tx_scrambler
    import pcs_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_advance,
    input  beat_t      i_data,
    output beat_t      o_data
);

    scr_state_t state_q;
    scr_state_t state_d;
    beat_t      scr_data;

    // Unroll the bit-serial recurrence over one beat, bit 0 first.
    always_comb begin
        logic       scr_bit;
        scr_state_t s;
        scr_bit  = 1'b0;
        s        = state_q;
        scr_data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            scr_bit     = i_data[i] ^ s[SCR_TAP_A-1] ^ s[SCR_TAP_B-1];
            scr_data[i] = scr_bit;
            s           = {s[SCR_TAP_B-2:0], scr_bit};
        end
        state_d = s;
    end

    // Scrambler history, seeded with all ones.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= SCR_RESET;
        end else if (i_advance) begin
            state_q <= state_d;
        end
    end

    assign o_data = scr_data;

endmodule

// File: rtl/tx_scramble_sequencer.sv
// TX PCS stage ahead of the gearbox: scrambles payload beats and produces
// the gearbox sequence count and pause slot as one registered bundle.
// Build option TX_SCRAMBLER_EN: when defined the payload is scrambled,
// otherwise it is passed through and no scrambler state exists.
// The sequence counter free-runs once enabled; a slot with no upstream
// beat sends a zero payload with header 00 and latches o_underflow.
module tx_scramble_sequencer
    import pcs_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic [HEADER_WIDTH-1:0]   i_header,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic [HEADER_WIDTH-1:0]   o_header,
    output logic [SEQUENCE_WIDTH-1:0] o_gearbox_seq,
    output logic                      o_pause,
    output logic                      o_underflow
);

    logic  en_q;
    seq_t  cnt_q;
    logic  slot;
    beat_t payload;
    beat_t payload_out;

    // A data slot is every enabled cycle except the pause slot.
    assign slot    = en_q && (cnt_q != SEQ_MAX);
    assign o_ready = slot;
    assign payload = i_valid ? i_data : '0;

`ifdef TX_SCRAMBLER_EN
    tx_scrambler u_scrambler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_advance (slot),
        .i_data    (payload),
        .o_data    (payload_out)
    );
`else
    assign payload_out = payload;
`endif

    // Enable one cycle after reset release, then free-running 0..32 count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            en_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            en_q <= 1'b1;
            if (en_q) begin
                cnt_q <= (cnt_q == SEQ_MAX) ? '0 : seq_t'(cnt_q + 1'b1);
            end
        end
    end

    // Output bundle: sequence/pause every enabled cycle, payload only in data slots.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data        <= '0;
            o_header      <= '0;
            o_gearbox_seq <= '0;
            o_pause       <= 1'b0;
            o_underflow   <= 1'b0;
        end else if (en_q) begin
            o_gearbox_seq <= cnt_q;
            o_pause       <= (cnt_q == SEQ_MAX);
            if (slot) begin
                o_data   <= payload_out;
                o_header <= i_valid ? i_header : '0;
                if (!i_valid) begin
                    o_underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_scramble_sequencer.sv
// Directed bench for tx_scramble_sequencer. Works in either build of
// TX_SCRAMBLER_EN; a bit-serial reference scrambler supplies expected
// payloads, hand-computed constants pin the key points.
module tb_tx_scramble_sequencer;
    import pcs_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_data = '0;
    logic [1:0]  i_header = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] o_data;
    logic [1:0]  o_header;
    logic [5:0]  o_gearbox_seq;
    logic        o_pause;
    logic        o_underflow;

    tx_scramble_sequencer dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_data        (i_data),
        .i_header      (i_header),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_header      (o_header),
        .o_gearbox_seq (o_gearbox_seq),
        .o_pause       (o_pause),
        .o_underflow   (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: m_state[57] newest scrambled bit, m_state[0] oldest.
    logic [57:0] m_state = '1;
    logic        m_en = 1'b0;
    int          exp_cnt = 0;
    int          exp_seq = 0;
    logic        exp_pause = 1'b0;
    logic [31:0] exp_data = '0;
    logic [1:0]  exp_hdr = '0;
    logic        exp_uf = 1'b0;
    int          accepted = 0;
    int          pauses = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input logic [31:0] d, output logic [31:0] q);
`ifdef TX_SCRAMBLER_EN
        logic b;
        for (int i = 0; i < 32; i++) begin
            b       = d[i] ^ m_state[19] ^ m_state[0];
            q[i]    = b;
            m_state = {b, m_state[57:1]};
        end
`else
        q = d;
`endif
    endtask

    // One clock: check pre-edge ready, advance the model, check post-edge outputs.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [1:0] h);
        logic        exp_rdy;
        logic [31:0] q;
        i_valid  = v;
        i_data   = d;
        i_header = h;
        exp_rdy  = m_en && (exp_cnt != 32);
        check("ready", 64'(o_ready), 64'(exp_rdy));
        if (m_en) begin
            if (exp_rdy) begin
                model_beat(v ? d : 32'h0, q);
                exp_data = q;
                exp_hdr  = v ? h : 2'b00;
                if (!v) exp_uf = 1'b1;
                if (v) accepted++;
            end
            exp_seq   = exp_cnt;
            exp_pause = (exp_cnt == 32);
            exp_cnt   = (exp_cnt == 32) ? 0 : exp_cnt + 1;
        end
        m_en = 1'b1;
        @(posedge i_clk);
        #1;
        if (o_pause) pauses++;
        check("data", 64'(o_data), 64'(exp_data));
        check("header", 64'(o_header), 64'(exp_hdr));
        check("seq", 64'(o_gearbox_seq), 64'(exp_seq));
        check("pause", 64'(o_pause), 64'(exp_pause));
        check("underflow", 64'(o_underflow), 64'(exp_uf));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 64'(o_data), 64'h0);
        check({tag, "_header"}, 64'(o_header), 64'h0);
        check({tag, "_seq"}, 64'(o_gearbox_seq), 64'h0);
        check({tag, "_pause"}, 64'(o_pause), 64'h0);
        check({tag, "_underflow"}, 64'(o_underflow), 64'h0);
        check({tag, "_ready"}, 64'(o_ready), 64'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] held_data;
        logic [1:0]  held_hdr;
        logic        reuse;

        // Power-on reset
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("por");
        i_reset_n = 1'b1;

        // Enable cycle, then 66 cycles of continuous valid traffic
        cycle(1'b1, 32'h0, SYNC_DATA);
        reuse = 1'b0;
        d = '0;
        for (int i = 0; i < 66; i++) begin
            if (exp_cnt == 32) begin
                held_data = o_data;
                held_hdr  = o_header;
                d = 32'hA5A5_5A5A;
                cycle(1'b1, d, SYNC_CTRL);
                check("pause_hold_data", 64'(o_data), 64'(held_data));
                check("pause_hold_hdr", 64'(o_header), 64'(held_hdr));
                reuse = 1'b1;
            end else begin
                if (!reuse) d = (i < 2) ? 32'h0 : (32'h9E37_79B9 * i) ^ (i << 16);
                cycle(1'b1, d, reuse ? SYNC_CTRL : SYNC_DATA);
                if (reuse) check("after_pause_hdr", 64'(o_header), 64'(SYNC_CTRL));
                reuse = 1'b0;
            end
            if (i == 0) check("first_beat", 64'(o_data), 64'h0);
`ifdef TX_SCRAMBLER_EN
            if (i == 1) check("second_beat", 64'(o_data), 64'h03FF_FF80);
`else
            if (i == 1) check("second_beat", 64'(o_data), 64'h0);
`endif
        end
        check("beats_accepted", 64'(accepted), 64'd64);
        check("pause_count", 64'(pauses), 64'd2);

        // Underflow at count 5
        while (exp_cnt != 5) cycle(1'b1, 32'h1234_5678 + 32'(exp_cnt), SYNC_DATA);
        cycle(1'b0, 32'hFFFF_FFFF, SYNC_CTRL);
        check("uf_header", 64'(o_header), 64'h0);
        check("uf_flag", 64'(o_underflow), 64'h1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0F0F_0000 | 32'(i), SYNC_DATA);
        check("uf_sticky", 64'(o_underflow), 64'h1);

        // Asynchronous reset mid-stream at count 17
        while (exp_cnt != 17) cycle(1'b1, 32'hC001_0000 | 32'(exp_cnt), SYNC_DATA);
        i_reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        i_reset_n = 1'b1;
        m_state = '1;
        m_en = 1'b0;
        exp_cnt = 0; exp_seq = 0; exp_pause = 1'b0;
        exp_data = '0; exp_hdr = '0; exp_uf = 1'b0;
        cycle(1'b1, 32'h0, SYNC_DATA);
        check("rst_en_ready", 64'(o_ready), 64'h1);
        cycle(1'b1, 32'h0, SYNC_DATA);
        check("rst_first_beat", 64'(o_data), 64'h0);
        check("rst_first_seq", 64'(o_gearbox_seq), 64'h0);
        cycle(1'b1, 32'h0, SYNC_DATA);
`ifdef TX_SCRAMBLER_EN
        check("rst_second_beat", 64'(o_data), 64'h03FF_FF80);
`else
        check("rst_second_beat", 64'(o_data), 64'h0);
`endif

        // Header 10 with a recognisable payload
        cycle(1'b1, 32'hDEAD_BEEF, 2'b10);
`ifndef TX_SCRAMBLER_EN
        check("passthru_data", 64'(o_data), 64'hDEAD_BEEF);
`endif
        check("passthru_hdr", 64'(o_header), 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
